// File: rtl/inference_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : inference_scheduler
// Purpose  : Launches one inference at a time on the network, waits with a
//            timeout, then finds the argmax class serially and offers the result.
// Revision : 1.0
// ============================================================================
module inference_scheduler #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_INPUTS     = 2,
   parameter int NUM_OUTPUTS    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int COUNT_WIDTH    = 16,
   localparam int c_IDX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data [NUM_INPUTS],
   output logic signed [DATA_WIDTH-1:0] nn_inputs [NUM_INPUTS],
   output logic                         nn_inputs_ready,
   input  logic signed [DATA_WIDTH-1:0] nn_outputs [NUM_OUTPUTS],
   input  logic                         nn_outputs_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data [NUM_OUTPUTS],
   output logic [c_IDX_WIDTH-1:0]       out_argmax,
   output logic                         busy,
   output logic                         timeout_flag,
   output logic [COUNT_WIDTH-1:0]       inference_count
);

   localparam int c_WAIT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_WAIT_WIDTH-1:0] c_WAIT_LAST = c_WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [c_IDX_WIDTH-1:0]  c_SCAN_LAST = c_IDX_WIDTH'(NUM_OUTPUTS - 1);
   localparam logic [c_IDX_WIDTH-1:0]  c_SCAN_FIRST = c_IDX_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_SCAN   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                         r_state;
   state_t                         w_next_state;
   logic signed [DATA_WIDTH-1:0]   r_nn_inputs [NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0]   r_out_data [NUM_OUTPUTS];
   logic [c_IDX_WIDTH-1:0]         r_argmax;
   logic [c_IDX_WIDTH-1:0]         r_best;
   logic [c_IDX_WIDTH-1:0]         r_scan_idx;
   logic [c_WAIT_WIDTH-1:0]        r_wait_cnt;
   logic [COUNT_WIDTH-1:0]         r_count;
   logic                           r_timeout;
   logic                           w_wait_last;
   logic                           w_scan_last;
   logic                           w_better;

   assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);
   assign w_scan_last = (r_scan_idx == c_SCAN_LAST);

   // Strict greater-than keeps the lower index on ties.
   generate
      if (NUM_OUTPUTS > 1) begin : g_scan_cmp
         assign w_better = (r_out_data[r_scan_idx] > r_out_data[r_best]);
      end else begin : g_single_out
         assign w_better = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_next_state = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the terminal count beats the timeout.
            if (nn_outputs_ready) begin
               w_next_state = (NUM_OUTPUTS > 1) ? S_SCAN : S_DONE;
            end else if (w_wait_last) begin
               w_next_state = S_IDLE;
            end
         end
         S_SCAN: begin
            if (w_scan_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            r_nn_inputs[i] <= '0;
         end
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            r_out_data[i] <= '0;
         end
         r_argmax   <= '0;
         r_best     <= '0;
         r_scan_idx <= '0;
         r_wait_cnt <= '0;
         r_count    <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_nn_inputs <= in_data;
               end
            end
            S_LAUNCH: begin
               r_wait_cnt <= '0;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               if (nn_outputs_ready) begin
                  r_out_data <= nn_outputs;
                  r_best     <= '0;
                  r_scan_idx <= c_SCAN_FIRST;
                  if (NUM_OUTPUTS == 1) begin
                     r_argmax <= '0;
                  end
               end else if (w_wait_last) begin
                  r_timeout <= 1'b1;
               end
            end
            S_SCAN: begin
               if (w_better) begin
                  r_best <= r_scan_idx;
               end
               r_scan_idx <= r_scan_idx + 1'b1;
               if (w_scan_last) begin
                  r_argmax <= w_better ? r_scan_idx : r_best;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready        = (r_state == S_IDLE);
   assign busy            = (r_state != S_IDLE);
   assign out_valid       = (r_state == S_DONE);
   assign nn_inputs_ready = (r_state == S_LAUNCH);
   assign nn_inputs       = r_nn_inputs;
   assign out_data        = r_out_data;
   assign out_argmax      = r_argmax;
   assign timeout_flag    = r_timeout;
   assign inference_count = r_count;

endmodule
`default_nettype wire
